id_ex_ctrl: RTL
===============

# id_ex_ctrl

Pipelined decode-and-issue control for the 5-stage RISC-V core, sitting between the IF/ID and ID/EX registers. It decodes the IF/ID instruction into the control bundle and registers it into ID/EX. Compared with the earlier single-cycle, purely combinational decoder, it adds:
- load-use hazard stalling with bubble insertion;
- branch/jump flush;
- multi-cycle MUL/DIV issue with parametrised latency;
- JAL/JALR/LUI decode and illegal-opcode flagging.

## Interface
Parameters:
- MUL_LAT, 2: EX cycles for MUL-class ops (funct3[2]=0); must be ≥1.
- DIV_LAT, 8: EX cycles for DIV/REM-class ops (funct3[2]=1); must be ≥1.
- CNT_W, 4: latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- instr_i  in  32  IF/ID instruction
- valid_i  in  1  IF/ID holds a valid instruction
- ex_memread_i  in  1  instruction currently in EX is a load (fed back from ex_memread_o)
- ex_rd_i  in  5  rd of instruction in EX
- flush_i  in  1  taken branch/jump resolved in EX
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- flush_o  out  1  clear IF/ID (combinational, = flush_i)
- ex_valid_o, ex_alusrc_o, ex_regwrite_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o, ex_branch_o, ex_jump_o, ex_mdu_o, ex_illegal_o  out  1 each  registered control bundle
- ex_aluop_o  out  3  registered ALU op class
- ex_rd_o  out  5  registered rd
- mdu_busy_o  out  1  MDU op occupying EX beyond its first cycle

## Operation
Decode (combinational, on instr_i):
- ALUOp classes: 000 add, 001 I-arith, 010 R-arith, 011 branch-compare, 100 pass-B.
- 0010011 I-arith: aluop=001, alusrc=1, regwrite=1.
- 0110011 R-type: aluop=010, regwrite=1. If funct7=0000001, also mdu=1.
- 0000011 lw: aluop=000, alusrc=1, regwrite=1, memread=1, memtoreg=1.
- 0100011 sw: aluop=000, alusrc=1, memwrite=1.
- 1100011 beq: aluop=011, branch=1.
- 1101111 jal: jump=1, regwrite=1.
- 1100111 jalr: jump=1, regwrite=1, alusrc=1.
- 0110111 lui: aluop=100, alusrc=1, regwrite=1.
- Any other opcode: all controls 0, illegal=1.
- rs1 is used by: R, I-arith, lw, sw, beq, jalr.
- rs2 is used by: R, sw, beq.

Hazard logic:
- load_use = ex_memread_i & ex_rd_i≠0 & valid_i & ((rs1 used & rs1=ex_rd_i) | (rs2 used & rs2=ex_rd_i)).
- mdu_busy = cnt≠0.
- stall_o = ~flush_i & (load_use | mdu_busy).

ID/EX update on each rising edge, in priority order:
1. flush_i: load a bubble (all bundle bits 0, ex_rd_o=0) and clear cnt.
2. mdu_busy: hold the ID/EX bundle; cnt decrements by 1.
3. load_use: load a bubble.
4. Otherwise: load the decoded bundle. ex_valid_o=valid_i; if valid_i=0, all controls are 0. If the loaded op is an MDU op, cnt=LAT−1 (MUL_LAT or DIV_LAT by funct3[2]).

Counter rules:
- Counter is CNT_W bits and never wraps; it decrements only while nonzero.

## Timing
- Reset (async assert): all ex_* outputs = 0, cnt = 0, mdu_busy_o = 0. Comb outputs follow inputs: stall_o = load_use term only, flush_o = flush_i.
- Decode-to-ID/EX latency is 1 cycle.
- Load-use costs exactly 1 bubble. The dependent instruction issues on the following cycle, once ex_memread_i has dropped.
- An MDU op occupies EX for exactly LAT cycles. stall_o is high for LAT−1 cycles starting the cycle after issue. LAT=1 gives no stall.
- Load-use and mdu_busy together: mdu_busy takes priority (hold). Load-use is re-evaluated after release.
- flush_i during mdu_busy: the bubble wins and the MDU op is abandoned.
- Reset asserted mid-MDU: cnt clears immediately.

## Structure
- Shared package (`core_pkg`) holds:
  - opcode constants;
  - ALUOp class constants;
  - a packed `ctrl_t` struct for the bundle, plus a `CTRL_BUBBLE` constant.
- One natural sub-module: `ctrl_decode`, the combinational opcode → `ctrl_t` decoder, including rs-used flags.
- The top module holds the hazard logic, the latency counter and the ID/EX register.

## Test plan
- Reset mid-stream: assert rst_i asynchronously -> all ex_* = 0 and mdu_busy_o = 0 the same cycle, before any clock edge.
- Load-use: issue `lw x5,0(x1)`, then `add x6,x5,x2` -> stall_o=1 for one cycle, one bubble (ex_valid_o=0), add issues the next cycle with aluop=010.
- No false hazard: `lw x0,...` followed by `add x6,x0,x0` -> no stall. `lw x5` followed by `lui x5` -> no stall (rs not used).
- MDU latency: with DIV_LAT=8, issue `div x3,x4,x5` -> ex_mdu_o=1 held for 8 cycles and stall_o=1 for 7. `mul` with MUL_LAT=2 -> stall_o=1 for 1 cycle.
- Flush during DIV busy: div in EX with cnt=4, pulse flush_i -> next edge gives ex_valid_o=0, cnt=0, stall_o=0.
- Decode sweep: each opcode in the list plus `7'b1111111` -> bundle matches the decode list; illegal opcode gives ex_illegal_o=1 with all other controls 0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: opcode and ALU-class constants plus the ID/EX control bundle type.
package core_pkg;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] F7_MDU    = 7'b0000001;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_IARITH = 3'b001;
    localparam logic [2:0] ALU_RARITH = 3'b010;
    localparam logic [2:0] ALU_BRCMP  = 3'b011;
    localparam logic [2:0] ALU_PASSB  = 3'b100;

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       mdu;
        logic       illegal;
        logic [2:0] aluop;
        logic [4:0] rd;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode-to-bundle decoder with source-register usage flags.
module ctrl_decode
    import core_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        rs1_used_o,
    output logic        rs2_used_o,
    output logic        div_o
);
    logic [6:0] op;
    logic       unused_funct3;
    assign op            = instr_i[6:0];
    assign div_o         = instr_i[14];
    assign unused_funct3 = ^instr_i[13:12];
    always_comb begin
        ctrl_o       = CTRL_BUBBLE;
        ctrl_o.valid = 1'b1;
        ctrl_o.rd    = instr_i[11:7];
        rs1_used_o   = 1'b0;
        rs2_used_o   = 1'b0;
        case (op)
            OP_IMM: begin
                ctrl_o.aluop    = ALU_IARITH;
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                rs1_used_o      = 1'b1;
            end
            OP_REG: begin
                ctrl_o.aluop    = ALU_RARITH;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.mdu      = instr_i[31:25] == F7_MDU;
                rs1_used_o      = 1'b1;
                rs2_used_o      = 1'b1;
            end
            OP_LOAD: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memread  = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                rs1_used_o      = 1'b1;
            end
            OP_STORE: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memwrite = 1'b1;
                rs1_used_o      = 1'b1;
                rs2_used_o      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_o.aluop  = ALU_BRCMP;
                ctrl_o.branch = 1'b1;
                rs1_used_o    = 1'b1;
                rs2_used_o    = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.jump     = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            OP_JALR: begin
                ctrl_o.jump     = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.alusrc   = 1'b1;
                rs1_used_o      = 1'b1;
            end
            OP_LUI: begin
                ctrl_o.aluop    = ALU_PASSB;
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl: hazard detection, MDU latency counter and the ID/EX control register.
// An MDU op holds ID/EX for LAT cycles; flush always wins and abandons it.
module id_ex_ctrl
    import core_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        ex_valid_o,
    output logic        ex_alusrc_o,
    output logic        ex_regwrite_o,
    output logic        ex_memtoreg_o,
    output logic        ex_memread_o,
    output logic        ex_memwrite_o,
    output logic        ex_branch_o,
    output logic        ex_jump_o,
    output logic        ex_mdu_o,
    output logic        ex_illegal_o,
    output logic [2:0]  ex_aluop_o,
    output logic [4:0]  ex_rd_o,
    output logic        mdu_busy_o
);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    ctrl_t            dec, ctrl_d, ctrl_q;
    logic             rs1_used, rs2_used, div_op, load_use, mdu_busy, mdu_issue;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    ctrl_decode u_dec (
        .instr_i   (instr_i),
        .ctrl_o    (dec),
        .rs1_used_o(rs1_used),
        .rs2_used_o(rs2_used),
        .div_o     (div_op)
    );

    assign load_use = ex_memread_i & (ex_rd_i != 5'd0) & valid_i &
                      ((rs1_used & (instr_i[19:15] == ex_rd_i)) |
                       (rs2_used & (instr_i[24:20] == ex_rd_i)));
    assign mdu_busy  = cnt_q != '0;
    assign mdu_issue = valid_i & ~load_use & dec.mdu;
    assign stall_o   = ~flush_i & (load_use | mdu_busy);
    assign flush_o   = flush_i;

    always_comb begin
        ctrl_d = flush_i ? CTRL_BUBBLE : mdu_busy ? ctrl_q : (load_use | ~valid_i) ? CTRL_BUBBLE : dec;
        cnt_d  = flush_i ? '0 : mdu_busy ? cnt_q - CNT_W'(1) : mdu_issue ? (div_op ? DIV_CNT : MUL_CNT) : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q <= CTRL_BUBBLE;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_valid_o    = ctrl_q.valid;
    assign ex_alusrc_o   = ctrl_q.alusrc;
    assign ex_regwrite_o = ctrl_q.regwrite;
    assign ex_memtoreg_o = ctrl_q.memtoreg;
    assign ex_memread_o  = ctrl_q.memread;
    assign ex_memwrite_o = ctrl_q.memwrite;
    assign ex_branch_o   = ctrl_q.branch;
    assign ex_jump_o     = ctrl_q.jump;
    assign ex_mdu_o      = ctrl_q.mdu;
    assign ex_illegal_o  = ctrl_q.illegal;
    assign ex_aluop_o    = ctrl_q.aluop;
    assign ex_rd_o       = ctrl_q.rd;
    assign mdu_busy_o    = mdu_busy;
endmodule
